// File: rtl/dmp_gather_accum.sv
// Gathers per-thread pagerank contribution beats, sums them lane-wise, then applies damping and base term.
// Optional build macro DMP_ACCUM_SAT_EN makes lane adds and the damping sum saturate instead of wrap.
module dmp_gather_accum #(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned NODES_IN_GRAPH = 32,
  parameter logic [63:0] DAMP_Q         = 64'h0000_0000_D999_999A,
  parameter logic [63:0] BASE_Q         = 64'h0000_0000_2666_6666
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_start,
  input  logic                         in_last,
  input  logic [64*NODES_IN_GRAPH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [64*NODES_IN_GRAPH-1:0] out_rank,
  output logic [15:0]                  out_iter,
  output logic                         err_proto,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(NUM_HW_THREADS + 1);
  localparam logic [CNT_W-1:0] NUM_CNT = CNT_W'(NUM_HW_THREADS);

  typedef enum logic [1:0] {IDLE, ACCUM, APPLY, HOLD} state_t;

  state_t                                state_q, state_d;
  logic [NODES_IN_GRAPH-1:0][63:0]       acc_q, acc_d;
  logic [NODES_IN_GRAPH-1:0][63:0]       rank_q, rank_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [15:0]                           iter_q, iter_d;
  logic                                  err_q, err_d;
  logic                                  ovf_q, ovf_d;

  logic [64:0]                           addRes   [NODES_IN_GRAPH];
  logic [64:0]                           applyRes [NODES_IN_GRAPH];
  logic                                  accCarry, applyCarry;
  logic                                  beat, reach;
  logic [CNT_W-1:0]                      cntNext;

  // Bit 64 carries the carry-out; the low 64 bits are the wrapped or saturated sum.
  function automatic logic [64:0] addLane(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef DMP_ACCUM_SAT_EN
    if (s[64]) s[63:0] = '1;
`endif
    return s;
  endfunction

  always_comb begin
    accCarry   = 1'b0;
    applyCarry = 1'b0;
    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
      addRes[i]   = addLane(acc_q[i], in_data[64*i +: 64]);
      applyRes[i] = addLane(BASE_Q, 64'((128'(DAMP_Q) * 128'(acc_q[i])) >> 32));
      accCarry    = accCarry | addRes[i][64];
      applyCarry  = applyCarry | applyRes[i][64];
    end
  end

  assign in_ready  = !reset && (state_q == IDLE || state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_rank  = rank_q;
  assign out_iter  = iter_q;
  assign err_proto = err_q;
  assign overflow  = ovf_q;
  assign beat      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rank_d  = rank_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    cntNext = cnt_q;
    reach   = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          if (!in_start && state_q == IDLE) begin
            err_d = 1'b1;
          end else begin
            // A start beat always restarts the sum, even mid-stream.
            if (in_start) begin
              acc_d   = in_data;
              cntNext = CNT_W'(1);
              if (state_q == ACCUM) err_d = 1'b1;
            end else begin
              for (int i = 0; i < NODES_IN_GRAPH; i++) acc_d[i] = addRes[i][63:0];
              cntNext = cnt_q + CNT_W'(1);
              if (accCarry) ovf_d = 1'b1;
            end
            cnt_d = cntNext;
            reach = (cntNext == NUM_CNT);
            if (in_last ^ reach) err_d = 1'b1;
            state_d = (in_last || reach) ? APPLY : ACCUM;
          end
        end
      end
      APPLY: begin
        for (int i = 0; i < NODES_IN_GRAPH; i++) rank_d[i] = applyRes[i][63:0];
        if (applyCarry) ovf_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          iter_d  = iter_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rank_q  <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rank_q  <= rank_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
